// File: rtl/beagleg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : beagleg_pkg                                            |
// | Description : Shared types and constants for the segment stepper:    |
// |               FSM state encoding, record byte offsets and defaults.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package beagleg_pkg;

  // Default FIFO word width and words per segment record
  localparam int c_default_word_size    = 8;
  localparam int c_default_record_words = 4;

  // Byte positions inside a record, in FIFO pop order
  localparam int c_byte_ctrl     = 0;  // [3:0] axis mask, [7:4] direction
  localparam int c_byte_count_lo = 1;
  localparam int c_byte_count_hi = 2;
  localparam int c_byte_period   = 3;

  // Fixed datapath widths
  localparam int c_axes    = 4;
  localparam int c_count_w = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : step_pulse_gen                                         |
// | Description : Generates COUNT step intervals of INTERVAL cycles each;|
// |               pulse is high for the first PULSE_CYCLES cycles of     |
// |               every interval, done flags the final interval cycle.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module step_pulse_gen #(
  parameter int INTERVAL_W   = 13,
  parameter int COUNT_W      = 16,
  parameter int PULSE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic [COUNT_W-1:0]    count,
  output logic                  pulse,
  output logic                  done
);

  localparam logic [INTERVAL_W-1:0] c_pulse_cycles = INTERVAL_W'(PULSE_CYCLES);
  localparam logic [COUNT_W-1:0]    c_one          = COUNT_W'(1);

  logic                  r_active;
  logic [INTERVAL_W-1:0] r_phase;
  logic [INTERVAL_W-1:0] r_last;
  logic [COUNT_W-1:0]    r_remaining;

  logic w_wrap;

  // Phase wraps on the last cycle of each interval
  assign w_wrap = r_active && (r_phase == r_last);
  assign pulse  = r_active && (r_phase < c_pulse_cycles);
  assign done   = w_wrap && (r_remaining == c_one);

  // Interval phase counter and remaining-steps counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= 1'b0;
      r_phase     <= '0;
      r_last      <= '0;
      r_remaining <= '0;
    end else if (start) begin
      // A zero count never arms the generator
      r_active    <= (count != '0);
      r_phase     <= '0;
      r_last      <= interval - INTERVAL_W'(1);
      r_remaining <= count;
    end else if (r_active) begin
      if (w_wrap) begin
        r_phase <= '0;
        if (r_remaining == c_one) begin
          r_active <= 1'b0;
        end
        r_remaining <= r_remaining - c_one;
      end else begin
        r_phase <= r_phase + INTERVAL_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/segment_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : segment_stepper                                        |
// | Description : Pops fixed-size segment records from an upstream FIFO  |
// |               and plays each one out as step/dir pulses on 4 axes.   |
// |               Optional build macro SEGMENT_STEPPER_ABORT_EN adds an  |
// |               abort input that drops the current segment.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module segment_stepper
  import beagleg_pkg::*;
#(
  parameter int WORD_SIZE    = c_default_word_size,
  parameter int RECORD_WORDS = c_default_record_words,
  parameter int PERIOD_SHIFT = 4,
  parameter int PULSE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SEGMENT_STEPPER_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 fifo_read_en,
  output logic [c_axes-1:0]    step,
  output logic [c_axes-1:0]    dir,
  output logic                 busy,
  output logic [c_count_w-1:0] segments_done
);

  // Word counters must be able to hold RECORD_WORDS itself
  localparam int c_cnt_w      = $clog2(RECORD_WORDS + 1);
  // (period + 1) needs 9 bits before the shift
  localparam int c_interval_w = 9 + PERIOD_SHIFT;

  localparam logic [c_cnt_w-1:0] c_rec_words = c_cnt_w'(RECORD_WORDS);
  localparam logic [c_cnt_w-1:0] c_last_word = c_cnt_w'(RECORD_WORDS - 1);

  state_t r_state;
  state_t w_state_next;

  // Fetch bookkeeping: pops issued, words captured, capture due this cycle
  logic [c_cnt_w-1:0] r_issued;
  logic [c_cnt_w-1:0] r_captured;
  logic               r_pending;

  logic [WORD_SIZE-1:0] r_record [RECORD_WORDS];

  logic [c_axes-1:0]    r_mask;
  logic [c_axes-1:0]    r_dir;
  logic [c_count_w-1:0] r_seg_done;

  logic w_pop;
  logic w_load;
  logic w_start;
  logic w_seg_inc;
  logic w_fetch_clear;
  logic w_pulse;
  logic w_done;

  logic [7:0]              w_ctrl;
  logic [7:0]              w_period;
  logic [c_count_w-1:0]    w_count;
  logic [c_interval_w-1:0] w_interval;

  // Record field decode from the assembled words
  assign w_ctrl     = r_record[c_byte_ctrl][7:0];
  assign w_period   = r_record[c_byte_period][7:0];
  assign w_count    = {r_record[c_byte_count_hi][7:0], r_record[c_byte_count_lo][7:0]};
  assign w_interval = c_interval_w'({1'b0, w_period} + 9'd1) << PERIOD_SHIFT;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    w_start       = 1'b0;
    w_seg_inc     = 1'b0;
    w_fetch_clear = (r_state == ST_LOAD);
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Pop only while words are available and the record is not complete
        w_pop = !fifo_empty && (r_issued != c_rec_words);
        if (r_pending && (r_captured == c_last_word)) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load = 1'b1;
        if (w_count == '0) begin
          w_seg_inc    = 1'b1;
          w_state_next = fifo_empty ? ST_IDLE : ST_FETCH;
        end else begin
          w_start      = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_done) begin
          w_seg_inc    = 1'b1;
          w_state_next = fifo_empty ? ST_IDLE : ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
`ifdef SEGMENT_STEPPER_ABORT_EN
    // Abort overrides everything: drop to IDLE, keep dir and segment count
    if (abort) begin
      w_state_next  = ST_IDLE;
      w_pop         = 1'b0;
      w_load        = 1'b0;
      w_start       = 1'b0;
      w_seg_inc     = 1'b0;
      w_fetch_clear = 1'b1;
    end
`endif
  end

  // Fetch counters; a capture lands one cycle after its pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued   <= '0;
      r_captured <= '0;
      r_pending  <= 1'b0;
    end else if (w_fetch_clear) begin
      r_issued   <= '0;
      r_captured <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_pop;
      if (w_pop) begin
        r_issued <= r_issued + c_cnt_w'(1);
      end
      if (r_pending) begin
        r_captured <= r_captured + c_cnt_w'(1);
      end
    end
  end

  // Record word capture, slot chosen by the capture counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RECORD_WORDS; i++) begin
        r_record[i] <= '0;
      end
    end else if (r_pending) begin
      for (int i = 0; i < RECORD_WORDS; i++) begin
        if (r_captured == c_cnt_w'(i)) begin
          r_record[i] <= fifo_data;
        end
      end
    end
  end

  // Segment parameters latched in LOAD; dir persists after the segment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_dir  <= '0;
    end else if (w_load) begin
      r_mask <= w_ctrl[3:0];
      r_dir  <= w_ctrl[7:4];
    end
  end

  // Completed-segment counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_done <= '0;
    end else if (w_seg_inc) begin
      r_seg_done <= r_seg_done + c_count_w'(1);
    end
  end

  step_pulse_gen #(
    .INTERVAL_W   (c_interval_w),
    .COUNT_W      (c_count_w),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .interval (w_interval),
    .count    (w_count),
    .pulse    (w_pulse),
    .done     (w_done)
  );

  // Steps only reach the pins while running a segment
  assign step          = (r_state == ST_RUN) ? (r_mask & {c_axes{w_pulse}}) : '0;
  assign dir           = r_dir;
  assign busy          = (r_state != ST_IDLE);
  assign fifo_read_en  = w_pop;
  assign segments_done = r_seg_done;

endmodule
`default_nettype wire

// File: tb/tb_segment_stepper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_segment_stepper                                     |
// | Description : Directed self-checking bench for segment_stepper with  |
// |               a simple FIFO model (data valid the cycle after pop).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_segment_stepper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_data = '0;
  logic        fifo_read_en;
  logic [3:0]  step;
  logic [3:0]  dir;
  logic        busy;
  logic [15:0] segments_done;
`ifdef SEGMENT_STEPPER_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // FIFO model
  logic [7:0] mem [0:255];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int bad_pops = 0;

  // Observation results
  int         n_rise;
  int         n_high;
  int         max_run;
  int         rises [16];
  logic [3:0] rise_mask [16];
  bit         timed_out;

  segment_stepper #(
    .WORD_SIZE    (8),
    .RECORD_WORDS (4),
    .PERIOD_SHIFT (4),
    .PULSE_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef SEGMENT_STEPPER_ABORT_EN
    .abort         (abort),
`endif
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_read_en  (fifo_read_en),
    .step          (step),
    .dir           (dir),
    .busy          (busy),
    .segments_done (segments_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Pop returns data on the following cycle; popping an empty FIFO is an error
  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (wr_ptr == rd_ptr) begin
        bad_pops <= bad_pops + 1;
      end else begin
        fifo_data <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_rec(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    push(b0);
    push(b1);
    push(b2);
    push(b3);
  endtask

  // Record step activity until busy falls (bounded)
  task automatic observe(input int max_cyc);
    logic [3:0] prev;
    int         run;
    bit         seen_busy;
    n_rise    = 0;
    n_high    = 0;
    max_run   = 0;
    timed_out = 1'b1;
    run       = 0;
    prev      = '0;
    seen_busy = busy;
    for (int i = 0; i < 16; i++) begin
      rises[i]     = 0;
      rise_mask[i] = '0;
    end
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (step != 4'b0000) begin
        n_high++;
        run++;
        if (run > max_run) max_run = run;
        if (prev == 4'b0000) begin
          if (n_rise < 16) begin
            rises[n_rise]     = cyc;
            rise_mask[n_rise] = step;
          end
          n_rise++;
        end
      end else begin
        run = 0;
      end
      prev = step;
      if (busy) begin
        seen_busy = 1'b1;
      end else if (seen_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (step !== 4'b0000) $display("FAIL reset_step got %b want 0000", step); else n_pass++;
    n_checks++; if (dir !== 4'b0000) $display("FAIL reset_dir got %b want 0000", dir); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (segments_done !== 16'd0) $display("FAIL reset_segdone got %0d want 0", segments_done); else n_pass++;
    n_checks++; if (fifo_read_en !== 1'b0) $display("FAIL reset_rden got %b want 0", fifo_read_en); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_empty_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    push_rec(8'h21, 8'h03, 8'h00, 8'h00);
    observe(200);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL single_timeout got %b want 0", timed_out); else n_pass++;
    n_checks++; if (n_rise !== 3) $display("FAIL single_pulses got %0d want 3", n_rise); else n_pass++;
    n_checks++; if (n_high !== 24) $display("FAIL single_high_cycles got %0d want 24", n_high); else n_pass++;
    n_checks++; if (max_run !== 8) $display("FAIL single_width got %0d want 8", max_run); else n_pass++;
    n_checks++; if (rises[1] - rises[0] !== 16) $display("FAIL single_period1 got %0d want 16", rises[1] - rises[0]); else n_pass++;
    n_checks++; if (rises[2] - rises[1] !== 16) $display("FAIL single_period2 got %0d want 16", rises[2] - rises[1]); else n_pass++;
    n_checks++; if (rise_mask[0] !== 4'b0001) $display("FAIL single_mask got %b want 0001", rise_mask[0]); else n_pass++;
    n_checks++; if (dir !== 4'b0010) $display("FAIL single_dir got %b want 0010", dir); else n_pass++;
    n_checks++; if (segments_done !== 16'd1) $display("FAIL single_segdone got %0d want 1", segments_done); else n_pass++;
  endtask

  task automatic test_zero_count();
    push_rec(8'h0F, 8'h00, 8'h00, 8'h05);
    observe(60);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL zero_timeout got %b want 0", timed_out); else n_pass++;
    n_checks++; if (n_rise !== 0) $display("FAIL zero_pulses got %0d want 0", n_rise); else n_pass++;
    n_checks++; if (segments_done !== 16'd2) $display("FAIL zero_segdone got %0d want 2", segments_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_idle got %b want 0", busy); else n_pass++;
    n_checks++; if (dir !== 4'b0000) $display("FAIL zero_dir got %b want 0000", dir); else n_pass++;
  endtask

  task automatic test_back_to_back();
    // A: mask 3, dir 1, 2 steps, interval 16. B: mask 4, dir 8, 1 step, interval 32.
    push_rec(8'h13, 8'h02, 8'h00, 8'h00);
    push_rec(8'h84, 8'h01, 8'h00, 8'h01);
    observe(300);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL b2b_timeout got %b want 0", timed_out); else n_pass++;
    n_checks++; if (n_rise !== 3) $display("FAIL b2b_pulses got %0d want 3", n_rise); else n_pass++;
    n_checks++; if (rises[1] - rises[0] !== 16) $display("FAIL b2b_period got %0d want 16", rises[1] - rises[0]); else n_pass++;
    // Last A interval ends 16 after its rise; B's first pulse 6 cycles later
    n_checks++; if (rises[2] - rises[1] !== 22) $display("FAIL b2b_gap got %0d want 22", rises[2] - rises[1]); else n_pass++;
    n_checks++; if (rise_mask[0] !== 4'b0011) $display("FAIL b2b_mask_a got %b want 0011", rise_mask[0]); else n_pass++;
    n_checks++; if (rise_mask[2] !== 4'b0100) $display("FAIL b2b_mask_b got %b want 0100", rise_mask[2]); else n_pass++;
    n_checks++; if (n_high !== 24) $display("FAIL b2b_high_cycles got %0d want 24", n_high); else n_pass++;
    n_checks++; if (dir !== 4'b1000) $display("FAIL b2b_dir got %b want 1000", dir); else n_pass++;
    n_checks++; if (segments_done !== 16'd4) $display("FAIL b2b_segdone got %0d want 4", segments_done); else n_pass++;
  endtask

  task automatic test_stall();
    int r0;
    int stall_pops;
    int waited;
    r0 = rd_ptr;
    stall_pops = 0;
    waited = 0;
    push(8'h52);
    push(8'h02);
    while ((rd_ptr != r0 + 2) && (waited < 20)) begin
      tick();
      waited++;
    end
    n_checks++; if (rd_ptr !== r0 + 2) $display("FAIL stall_first_pops got %0d want %0d", rd_ptr - r0, 2); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_read_en) stall_pops++;
    end
    n_checks++; if (stall_pops !== 0) $display("FAIL stall_pops got %0d want 0", stall_pops); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (dir !== 4'b1000) $display("FAIL stall_dir_hold got %b want 1000", dir); else n_pass++;
    push(8'h00);
    push(8'h00);
    observe(200);
    n_checks++; if (timed_out !== 1'b0) $display("FAIL stall_timeout got %b want 0", timed_out); else n_pass++;
    n_checks++; if (n_rise !== 2) $display("FAIL stall_pulses got %0d want 2", n_rise); else n_pass++;
    n_checks++; if (rise_mask[0] !== 4'b0010) $display("FAIL stall_mask got %b want 0010", rise_mask[0]); else n_pass++;
    n_checks++; if (rises[1] - rises[0] !== 16) $display("FAIL stall_period got %0d want 16", rises[1] - rises[0]); else n_pass++;
    n_checks++; if (dir !== 4'b0101) $display("FAIL stall_dir got %b want 0101", dir); else n_pass++;
    n_checks++; if (segments_done !== 16'd5) $display("FAIL stall_segdone got %0d want 5", segments_done); else n_pass++;
    n_checks++; if (rd_ptr !== r0 + 4) $display("FAIL stall_total_pops got %0d want 4", rd_ptr - r0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rises_seen;
    int rp;
    int rst_pops;
    logic [3:0] prev;
    rises_seen = 0;
    rst_pops = 0;
    prev = '0;
    push_rec(8'h11, 8'h05, 8'h00, 8'h00);
    for (int i = 0; (i < 200) && (rises_seen < 2); i++) begin
      tick();
      if ((step != 4'b0000) && (prev == 4'b0000)) rises_seen++;
      prev = step;
    end
    tick(); tick(); tick();
    n_checks++; if (step !== 4'b0001) $display("FAIL rmid_pre_step got %b want 0001", step); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (step !== 4'b0000) $display("FAIL rmid_step got %b want 0000", step); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (dir !== 4'b0000) $display("FAIL rmid_dir got %b want 0000", dir); else n_pass++;
    n_checks++; if (segments_done !== 16'd0) $display("FAIL rmid_segdone got %0d want 0", segments_done); else n_pass++;
    push_rec(8'h31, 8'h01, 8'h00, 8'h00);
    rp = rd_ptr;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fifo_read_en) rst_pops++;
    end
    n_checks++; if (rst_pops !== 0) $display("FAIL rmid_rden_in_reset got %0d want 0", rst_pops); else n_pass++;
    n_checks++; if (rd_ptr !== rp) $display("FAIL rmid_fifo_untouched got %0d want %0d", rd_ptr, rp); else n_pass++;
    rst_n = 1'b1;
    observe(100);
    n_checks++; if (n_rise !== 1) $display("FAIL rmid_after_pulses got %0d want 1", n_rise); else n_pass++;
    n_checks++; if (dir !== 4'b0011) $display("FAIL rmid_after_dir got %b want 0011", dir); else n_pass++;
    n_checks++; if (segments_done !== 16'd1) $display("FAIL rmid_after_segdone got %0d want 1", segments_done); else n_pass++;
    n_checks++; if (rd_ptr !== rp + 4) $display("FAIL rmid_after_pops got %0d want 4", rd_ptr - rp); else n_pass++;
  endtask

`ifdef SEGMENT_STEPPER_ABORT_EN
  task automatic test_abort();
    logic [15:0] sd;
    int          waited;
    int          ab_pops;
    waited = 0;
    ab_pops = 0;
    push_rec(8'h11, 8'h05, 8'h00, 8'h00);
    while ((step == 4'b0000) && (waited < 100)) begin
      tick();
      waited++;
    end
    tick(); tick();
    sd = segments_done;
    abort = 1'b1;
    tick();
    n_checks++; if (step !== 4'b0000) $display("FAIL abort_step got %b want 0000", step); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (segments_done !== sd) $display("FAIL abort_segdone got %0d want %0d", segments_done, sd); else n_pass++;
    n_checks++; if (dir !== 4'b0001) $display("FAIL abort_dir got %b want 0001", dir); else n_pass++;
    push_rec(8'h21, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fifo_read_en || busy) ab_pops++;
    end
    n_checks++; if (ab_pops !== 0) $display("FAIL abort_hold got %0d want 0", ab_pops); else n_pass++;
    abort = 1'b0;
    observe(100);
    n_checks++; if (segments_done !== sd + 16'd1) $display("FAIL abort_resume_segdone got %0d want %0d", segments_done, sd + 16'd1); else n_pass++;
    n_checks++; if (dir !== 4'b0010) $display("FAIL abort_resume_dir got %b want 0010", dir); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_zero_count();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef SEGMENT_STEPPER_ABORT_EN
    test_abort();
`endif
    n_checks++; if (bad_pops !== 0) $display("FAIL empty_pops got %0d want 0", bad_pops); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/segment_stepper.md
SEGMENT_STEPPER -- requirements
Module: segment_stepper

Interface
REQ-001 SHALL have parameter WORD_SIZE, 8, FIFO word width in bits.
REQ-002 SHALL have parameter RECORD_WORDS, 4, words per segment record.
REQ-003 SHALL have parameter PERIOD_SHIFT, 4, left shift applied to the period byte to form the step interval.
REQ-004 SHALL have parameter PULSE_CYCLES, 8, step high time in clk cycles; must be less than or equal to 1<<PERIOD_SHIFT.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port fifo_empty, input, 1, upstream FIFO holds no words.
REQ-008 SHALL have port fifo_data, input, WORD_SIZE, FIFO read word, valid the cycle after fifo_read_en.
REQ-009 SHALL have port fifo_read_en, output, 1, pops one FIFO word.
REQ-010 SHALL have port step, output, 4, per-axis step pulses.
REQ-011 SHALL have port dir, output, 4, per-axis direction.
REQ-012 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-013 SHALL have port segments_done, output, 16, count of completed segments; wraps from 0xFFFF to 0.

Function
REQ-014 SHALL decode records in pop order as follows.
- Byte0[3:0]: axis mask. Byte0[7:4]: dir.
- Byte1: count LSB. Byte2: count MSB.
- Byte3: period.
REQ-015 SHALL use states IDLE, FETCH, LOAD, RUN.
REQ-016 SHALL go from IDLE to FETCH on the first cycle fifo_empty==0.
REQ-017 In FETCH, SHALL assert fifo_read_en only when fifo_empty==0, and at most one pop per cycle.
- Capture fifo_data one cycle later; stall with no pop while empty.
- After RECORD_WORDS captures, go to LOAD.
REQ-018 SHALL hold a partially fetched record across empty stalls indefinitely, with no timeout.
REQ-019 In LOAD (one cycle), SHALL update dir from Byte0[7:4], latch mask/count/interval, and set interval = (period+1)<<PERIOD_SHIFT.
REQ-020 SHALL handle LOAD with count==0 as follows: emit no pulses, increment segments_done, go to FETCH if fifo_empty==0, else IDLE.
REQ-021 In RUN, SHALL drive step = mask for PULSE_CYCLES cycles starting the first RUN cycle, then 0 for the rest of the interval; this repeats count times.
REQ-022 SHALL keep step 0 outside RUN.
REQ-023 After the last interval ends, SHALL increment segments_done once and go to FETCH if fifo_empty==0, else IDLE.
- Back-to-back segments leave no gap beyond FETCH+LOAD.
REQ-024 SHALL hold dir stable through RUN and keep its value after the segment ends.
REQ-025 SHALL never assert fifo_read_en outside FETCH.

Reset
REQ-026 While rst_n==0, SHALL force state=IDLE, step=0, dir=0, fifo_read_en=0, busy=0, segments_done=0, and clear all internal counters.
REQ-027 SHALL treat reset mid-segment as follows: discard the partial record and the remaining steps, and leave the FIFO contents untouched.

Configuration
REQ-028 With SEGMENT_STEPPER_ABORT_EN defined, SHALL add input abort (1 bit).
- abort==1 in any state: next cycle state=IDLE, step=0, partial record discarded.
- dir and segments_done unchanged.
- IDLE held while abort==1.
REQ-029 Without SEGMENT_STEPPER_ABORT_EN, SHALL have no abort port and no abort logic.

Structure
REQ-030 SHALL place the state enum, record byte offsets, and WORD_SIZE/RECORD_WORDS defaults in shared package beagleg_pkg.
REQ-031 SHALL implement the interval/pulse-width counter as sub-module step_pulse_gen, with inputs start, interval, count and outputs pulse, done.

Verification
REQ-032 Record {0x21,0x03,0x00,0x00} with PERIOD_SHIFT=4 SHALL produce step==4'b0001 three times, each 8 cycles high with a 16-cycle period; dir==4'b0010; segments_done==1.
REQ-033 Record {0x0F,0x00,0x00,0x05} SHALL produce no step pulses, segments_done incremented, and return to IDLE.
REQ-034 Two records queued with fifo_empty==0 throughout SHALL produce the second segment's first pulse exactly RECORD_WORDS+2 cycles after the first segment's last interval ends.
REQ-035 fifo_empty raised for 10 cycles after the second word SHALL cause no pops during the stall, a correctly assembled record afterward, and the correct count.
REQ-036 rst_n pulled low during the 2nd of 5 steps SHALL clear step immediately, keep outputs at reset values, and cause no FIFO pop until rst_n is high and fifo_empty==0.
REQ-037 With SEGMENT_STEPPER_ABORT_EN, abort pulsed mid-RUN SHALL give step==0 the next cycle, state IDLE, and segments_done unchanged.
